commit_checker: RTL and testbench
=================================

COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter XLEN, default 32, register/memory data width and PC width.
REQ-002 Parameter RAW, default 4, register-index width.
REQ-003 Parameter DEPTH, default 8, per-side FIFO depth, power of two, >=2.
REQ-004 Parameter TIMEOUT, default 1024, max cycles one FIFO may be non-empty while the other stays empty.
REQ-005 Parameter STOP_ON_ERR, default 1, 1 = halt comparison on first mismatch.
REQ-006 Parameter R0_ZERO, default 1, 1 = register writes to index 0 count as no write.
REQ-007 clk  in  1  single clock, all logic rising-edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 en  in  1  start comparison, level.
REQ-010 clr  in  1  synchronous flush of FIFOs, counters, flags; return to IDLE.
REQ-011 d_valid / d_ready  in / out  1 / 1  DUT commit handshake.
REQ-012 d_pkt  in  PKT_W  DUT commit record; PKT_W = 3*XLEN+RAW+2.
REQ-013 m_valid / m_ready  in / out  1 / 1  model commit handshake.
REQ-014 m_pkt  in  PKT_W  model commit record, same layout.
REQ-015 match / mismatch  out  1 / 1  one-cycle pulses per compared pair.
REQ-016 err_pc  out  XLEN  DUT PC of first mismatch.
REQ-017 err_sticky / timeout  out  1 / 1  sticky error flags.
REQ-018 match_cnt / mismatch_cnt  out  32 / 32  saturating counters.
REQ-019 state  out  2  IDLE=0, RUN=1, HALT=2.

Function
REQ-020 Packet layout MSB->LSB: pc[XLEN], rd_we, rd_addr[RAW], rd_data[XLEN], st_we, st_addr/data packed as st_data[XLEN] only after st_we; store address = pc-independent field carried in rd_data when rd_we=0 is forbidden -- encoder places store address in upper XLEN, data in lower XLEN via rd_data/st_data reuse is not used.
REQ-021 Simplified decision: record fields = pc, rd_we, rd_addr, rd_data, st_we, st_data (PKT_W = 3*XLEN+RAW+2).
REQ-022 Push on d_valid&&d_ready (m likewise) into own FIFO, any state except during clr/reset.
REQ-023 x_ready = !full of that FIFO; no push bypass when full even if popping same cycle.
REQ-024 FIFO pointers wrap modulo DEPTH; occupancy 0..DEPTH, full at DEPTH.
REQ-025 IDLE->RUN when en=1; RUN->IDLE when en=0 (FIFO contents retained).
REQ-026 In RUN, both FIFOs non-empty -> pop both heads same cycle, compare, result pulse registered next cycle (latency 1).
REQ-027 Pair matches iff pc equal, effective rd_we equal, if rd_we then rd_addr and rd_data equal, st_we equal, if st_we then st_data equal.
REQ-028 R0_ZERO=1: rd_we with rd_addr==0 treated as rd_we=0, rd_addr/rd_data ignored.
REQ-029 Mismatch: mismatch pulse, mismatch_cnt+1, err_sticky=1; err_pc captured only if err_sticky was 0.
REQ-030 STOP_ON_ERR=1: RUN->HALT on mismatch; HALT pops nothing, still accepts pushes until full; exit only via clr or reset.
REQ-031 Counters saturate at 32'hFFFF_FFFF.
REQ-032 Timeout counter counts cycles in RUN with exactly one FIFO non-empty, zeroes otherwise; reaching TIMEOUT sets timeout (sticky), no state change.
REQ-033 clr has priority over push/pop/compare in the same cycle; pushes that cycle are dropped.

Reset
REQ-034 rst_n=0 at a clock edge: FIFOs empty, state=IDLE, all flags/pulses/counters/err_pc 0, d_ready=m_ready=0 during reset, 1 on first cycle after.
REQ-035 Reset mid-operation discards in-flight records and any pending result pulse.

Verification
REQ-036 DEPTH=4, en=1, push identical pc=0x10/rd r3=0x55 on both sides -> match pulse 1 cycle after pop, match_cnt=1, FIFOs empty.
REQ-037 Model rd_data=0x56 vs DUT 0x55 at pc=0x20 -> mismatch, err_pc=0x20, err_sticky=1, state=HALT, later pairs not popped.
REQ-038 DUT pushes 4 records, model none -> d_ready=0 after 4th push; TIMEOUT=16 -> timeout=1 after 16 cycles in RUN.
REQ-039 R0_ZERO=1, DUT rd r0=0x7 vs model rd_we=0, same pc -> match.
REQ-040 clr asserted with simultaneous push in HALT -> next cycle state=IDLE, counters/flags 0, both FIFOs empty.
REQ-041 rst_n low mid-stream with 3 queued records -> all outputs 0, FIFOs empty, no pulse after release.

Source files
------------

// File: rtl/commit_checker.sv
// Lock-step commit comparator: buffers DUT and model commit records in two FIFOs
// and compares them pairwise, reporting matches, mismatches and one-sided stalls.

module commit_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by cnt, so stale
    // entries are never read, and leaving reset off keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module commit_checker #(
    parameter int XLEN        = 32,
    parameter int RAW         = 4,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1024,
    parameter int STOP_ON_ERR = 1,
    parameter int R0_ZERO     = 1,
    localparam int PKT_W      = 3*XLEN + RAW + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [PKT_W-1:0] d_pkt,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [PKT_W-1:0] m_pkt,
    output logic             match,
    output logic             mismatch,
    output logic [XLEN-1:0]  err_pc,
    output logic             err_sticky,
    output logic             timeout,
    output logic [31:0]      match_cnt,
    output logic [31:0]      mismatch_cnt,
    output logic [1:0]       state
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            rd_we;
        logic [RAW-1:0]  rd_addr;
        logic [XLEN-1:0] rd_data;
        logic            st_we;
        logic [XLEN-1:0] st_data;
    } pkt_t;

    state_t     st;
    logic       d_empty, d_full, m_empty, m_full;
    logic       d_push, m_push, pop, same;
    pkt_t       d_head, m_head;
    logic [TW-1:0] tcnt;

    function automatic logic eff_we(pkt_t p);
        return p.rd_we && !((R0_ZERO != 0) && (p.rd_addr == '0));
    endfunction

    function automatic logic pkt_equal(pkt_t a, pkt_t b);
        logic wa, wb;
        wa = eff_we(a);
        wb = eff_we(b);
        return (a.pc == b.pc) && (wa == wb)
            && (!wa || ((a.rd_addr == b.rd_addr) && (a.rd_data == b.rd_data)))
            && (a.st_we == b.st_we)
            && (!a.st_we || (a.st_data == b.st_data));
    endfunction

    // Ready is forced low while reset is held so nothing is handshaken mid-reset.
    assign d_ready = rst_n && !d_full;
    assign m_ready = rst_n && !m_full;
    assign d_push  = d_valid && d_ready && !clr;
    assign m_push  = m_valid && m_ready && !clr;
    assign pop     = (st == RUN) && !d_empty && !m_empty && !clr;
    assign same    = pkt_equal(d_head, m_head);
    assign state   = st;

    commit_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_dfifo (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(d_push), .pop(pop),
        .wdata(d_pkt), .rdata(d_head), .empty(d_empty), .full(d_full)
    );

    commit_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_mfifo (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(m_push), .pop(pop),
        .wdata(m_pkt), .rdata(m_head), .empty(m_empty), .full(m_full)
    );

    // NOTE: reset is synchronous, so it lives inside the clocked block; every state
    // element uses <= so all updates see the pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            st           <= IDLE;
            match        <= 1'b0;
            mismatch     <= 1'b0;
            err_pc       <= '0;
            err_sticky   <= 1'b0;
            timeout      <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            tcnt         <= '0;
        end else begin
            match    <= 1'b0;
            mismatch <= 1'b0;

            case (st)
                IDLE:    if (en) st <= RUN;
                RUN: begin
                    if (pop && !same && (STOP_ON_ERR != 0)) st <= HALT;
                    else if (!en)                           st <= IDLE;
                end
                HALT:    st <= HALT;
                default: st <= IDLE;
            endcase

            if (pop) begin
                if (same) begin
                    match <= 1'b1;
                    if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
                end else begin
                    mismatch   <= 1'b1;
                    err_sticky <= 1'b1;
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (!err_sticky)        err_pc       <= d_head.pc;
                end
            end

            // One side is producing while the other is silent: count toward a stall.
            if ((st == RUN) && (d_empty != m_empty)) begin
                if (tcnt != TW'(TIMEOUT))       tcnt    <= tcnt + 1'b1;
                if (tcnt == TW'(TIMEOUT - 1))   timeout <= 1'b1;
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: a vector table of single-pair compares plus
// hand-written sequences for halt, clear, timeout and reset corner cases.

module tb_commit_checker;
    localparam int XLEN  = 32;
    localparam int RAW   = 4;
    localparam int PKT_W = 3*XLEN + RAW + 2;

    logic             clk = 1'b0;
    logic             rst_n, en, clr;
    logic             d_valid, d_ready, m_valid, m_ready;
    logic [PKT_W-1:0] d_pkt, m_pkt;
    logic             match, mismatch, err_sticky, timeout;
    logic [XLEN-1:0]  err_pc;
    logic [31:0]      match_cnt, mismatch_cnt;
    logic [1:0]       state;

    int n_cmp  = 0;
    int n_fail = 0;

    commit_checker #(
        .XLEN(XLEN), .RAW(RAW), .DEPTH(4), .TIMEOUT(16), .STOP_ON_ERR(1), .R0_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .d_valid(d_valid), .d_ready(d_ready), .d_pkt(d_pkt),
        .m_valid(m_valid), .m_ready(m_ready), .m_pkt(m_pkt),
        .match(match), .mismatch(mismatch), .err_pc(err_pc),
        .err_sticky(err_sticky), .timeout(timeout),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] d;
        logic [PKT_W-1:0] m;
        logic             exp_match;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [PKT_W-1:0] mk(logic [31:0] pc, logic we, logic [3:0] addr,
                                            logic [31:0] data, logic swe, logic [31:0] sdata);
        return {pc, we, addr, data, swe, sdata};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{mk(32'h10, 1, 3, 32'h55, 0, 0),  mk(32'h10, 1, 3, 32'h55, 0, 0),  1'b1};
        vecs[1] = '{mk(32'h20, 1, 3, 32'h55, 0, 0),  mk(32'h20, 1, 3, 32'h56, 0, 0),  1'b0};
        vecs[2] = '{mk(32'h30, 1, 0, 32'h7, 0, 0),   mk(32'h30, 0, 0, 32'h0, 0, 0),   1'b1};
        vecs[3] = '{mk(32'h40, 0, 2, 32'h11, 0, 0),  mk(32'h40, 0, 5, 32'h22, 0, 0),  1'b1};
        vecs[4] = '{mk(32'h50, 0, 0, 0, 1, 32'hAA),  mk(32'h50, 0, 0, 0, 1, 32'hAB),  1'b0};
        vecs[5] = '{mk(32'h60, 0, 0, 0, 0, 32'hAA),  mk(32'h60, 0, 0, 0, 0, 32'hBB),  1'b1};
        vecs[6] = '{mk(32'h70, 1, 1, 32'h1, 0, 0),   mk(32'h74, 1, 1, 32'h1, 0, 0),   1'b0};
        vecs[7] = '{mk(32'h80, 1, 5, 32'h9, 0, 0),   mk(32'h80, 0, 5, 32'h9, 0, 0),   1'b0};
        vecs[8] = '{mk(32'h90, 1, 5, 32'h9, 0, 0),   mk(32'h90, 1, 6, 32'h9, 0, 0),   1'b0};
        vecs[9] = '{mk(32'hA0, 1, 1, 32'h1, 1, 32'h33), mk(32'hA0, 1, 1, 32'h1, 1, 32'h33), 1'b1};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        d_valid = 1'b0; m_valid = 1'b0; d_pkt = '0; m_pkt = '0;

        // Reset state
        tick(); tick();
        check("rst_d_ready_low", 32'(d_ready), 32'd0);
        check("rst_m_ready_low", 32'(m_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_d_ready_after", 32'(d_ready), 32'd1);
        check("rst_m_ready_after", 32'(m_ready), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_flags", {28'd0, match, mismatch, err_sticky, timeout}, 32'd0);
        check("rst_counts", match_cnt | mismatch_cnt | err_pc, 32'd0);

        // Single-pair compares from the table
        for (int i = 0; i < 10; i++) begin
            do_clr();
            en = 1'b1;
            d_valid = 1'b1; m_valid = 1'b1;
            d_pkt = vecs[i].d; m_pkt = vecs[i].m;
            tick();
            d_valid = 1'b0; m_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_match", i), 32'(match), 32'(vecs[i].exp_match));
            check($sformatf("vec%0d_mismatch", i), 32'(mismatch), 32'(!vecs[i].exp_match));
            check($sformatf("vec%0d_state", i), 32'(state), vecs[i].exp_match ? 32'd1 : 32'd2);
            check($sformatf("vec%0d_match_cnt", i), match_cnt, vecs[i].exp_match ? 32'd1 : 32'd0);
            tick();
            check($sformatf("vec%0d_pulse_gone", i), 32'(match | mismatch), 32'd0);
        end

        // Mismatch halts; later pairs stay queued
        do_clr();
        en = 1'b1;
        d_valid = 1'b1; m_valid = 1'b1;
        d_pkt = mk(32'h20, 1, 3, 32'h55, 0, 0);
        m_pkt = mk(32'h20, 1, 3, 32'h56, 0, 0);
        tick();
        d_pkt = mk(32'h24, 1, 3, 32'h1, 0, 0);
        m_pkt = mk(32'h24, 1, 3, 32'h1, 0, 0);
        tick();
        check("halt_mismatch", 32'(mismatch), 32'd1);
        check("halt_err_pc", err_pc, 32'h20);
        check("halt_sticky", 32'(err_sticky), 32'd1);
        check("halt_state", 32'(state), 32'd2);
        m_valid = 1'b0;
        d_pkt = mk(32'h28, 0, 0, 0, 0, 0);
        tick();
        check("halt_pulse_gone", 32'(mismatch | match), 32'd0);
        tick(); tick();
        check("halt_d_full", 32'(d_ready), 32'd0);
        check("halt_m_ready", 32'(m_ready), 32'd1);
        check("halt_match_cnt", match_cnt, 32'd0);
        check("halt_mismatch_cnt", mismatch_cnt, 32'd1);

        // Clear in HALT with a simultaneous push
        d_valid = 1'b0;
        m_valid = 1'b1; m_pkt = mk(32'h99, 0, 0, 0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0; m_valid = 1'b0; en = 1'b0;
        check("clr_state", 32'(state), 32'd0);
        check("clr_flags", {29'd0, err_sticky, timeout, mismatch}, 32'd0);
        check("clr_counts", mismatch_cnt | match_cnt | err_pc, 32'd0);
        check("clr_ready", {30'd0, d_ready, m_ready}, 32'd3);
        en = 1'b1;
        d_valid = 1'b1; m_valid = 1'b1;
        d_pkt = mk(32'h44, 0, 0, 0, 0, 0); m_pkt = mk(32'h44, 0, 0, 0, 0, 0);
        tick();
        d_valid = 1'b0; m_valid = 1'b0;
        tick();
        check("clr_empty_match", 32'(match), 32'd1);
        check("clr_empty_cnt", match_cnt, 32'd1);

        // One-sided traffic: fill DUT FIFO and hit the timeout
        do_clr();
        en = 1'b1;
        d_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_pkt = mk(32'(i * 4), 0, 0, 0, 0, 0);
            tick();
        end
        d_valid = 1'b0;
        check("to_d_full", 32'(d_ready), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("to_not_yet", 32'(timeout), 32'd0);
        tick();
        check("to_set", 32'(timeout), 32'd1);
        check("to_state_run", 32'(state), 32'd1);
        tick();
        check("to_sticky", 32'(timeout), 32'd1);

        // Reset mid-stream with queued records and a pop pending
        do_clr();
        en = 1'b0;
        d_valid = 1'b1; m_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_pkt = mk(32'(16 + i), 0, 0, 0, 0, 0);
            m_pkt = mk(32'(16 + i), 0, 0, 0, 0, 0);
            tick();
        end
        d_valid = 1'b0; m_valid = 1'b0;
        check("idle_no_pop", match_cnt, 32'd0);
        en = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_match", 32'(match), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_ready", 32'(d_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_cnt", match_cnt | mismatch_cnt, 32'd0);
        check("post_rst_pulse", 32'(match | mismatch), 32'd0);
        check("post_rst_state", 32'(state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
